// File: rtl/mcp9808_sampler_if.sv
// Handshake between the sampler and the mcp9808 read engine: one-cycle update
// request out, idle flag and last temperature back.
interface mcp9808_sampler_if;
  logic        if_update;
  logic        if_ready;
  logic [12:0] if_temp;

  modport master (output if_update, input if_ready, input if_temp);
  modport slave  (input if_update, output if_ready, output if_temp);
endinterface

// File: rtl/mcp9808_sampler.sv
// Periodic / on-demand mcp9808 sampler: requests a read, waits for it to finish
// with a timeout, and keeps last, min, max, 4-sample average and sample count.
module mcp9808_sampler #(
  parameter int unsigned PERIOD_CYCLES  = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     trig,
  input  logic                     clear_stats,
  mcp9808_sampler_if.master        bus,
  output logic                     busy,
  output logic                     sample_valid,
  output logic [12:0]              temp_now,
  output logic [12:0]              temp_min,
  output logic [12:0]              temp_max,
  output logic [12:0]              temp_avg,
  output logic [15:0]              sample_cnt,
  output logic                     err
);

  localparam int unsigned PW = $clog2(PERIOD_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT_BUSY, WAIT_DONE, CAPTURE
  } state_e;

  state_e             state_q,  state_d;
  logic [PW-1:0]      period_q, period_d;
  logic [TW-1:0]      wait_q,   wait_d;
  logic               pend_q,   pend_d;
  logic               err_q,    err_d;
  logic [12:0]        now_q,    now_d;
  logic [12:0]        min_q,    min_d;
  logic [12:0]        max_q,    max_d;
  logic [3:0][12:0]   hist_q,   hist_d;
  logic [15:0]        cnt_q,    cnt_d;
  logic               capture;
  logic               timeout;
  logic signed [14:0] sum;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    period_d  = period_q;
    wait_d    = wait_q;
    pend_d    = pend_q | trig;
    err_d     = err_q;
    now_d     = now_q;
    min_d     = min_q;
    max_d     = max_q;
    hist_d    = hist_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    timeout   = 1'b0;
    bus.if_update = 1'b0;
    sample_valid  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!enable)                  period_d = '0;
        else if (period_q != PERIOD_LAST) period_d = period_q + PW'(1);
        if (bus.if_ready && (pend_q || trig || (enable && period_q == PERIOD_LAST))) begin
          state_d = REQ;
          pend_d  = 1'b0;
        end
      end
      REQ: begin
        bus.if_update = 1'b1;
        wait_d   = '0;
        period_d = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.if_ready) begin
          state_d = WAIT_DONE;
          wait_d  = '0;
        end else if (wait_q == TIMEOUT_LAST) timeout = 1'b1;
        else wait_d = wait_q + TW'(1);
      end
      WAIT_DONE: begin
        if (bus.if_ready)                 state_d = CAPTURE;
        else if (wait_q == TIMEOUT_LAST)  timeout = 1'b1;
        else                              wait_d  = wait_q + TW'(1);
      end
      CAPTURE: begin
        // A clear in the same cycle discards this sample entirely.
        capture      = !clear_stats;
        sample_valid = !clear_stats;
        period_d     = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      err_d    = 1'b1;
      period_d = '0;
      state_d  = IDLE;
    end

    if (capture) begin
      now_d = bus.if_temp;
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      if (cnt_q == 16'd0) begin
        hist_d = {4{bus.if_temp}};
        min_d  = bus.if_temp;
        max_d  = bus.if_temp;
      end else begin
        hist_d = {hist_q[2:0], bus.if_temp};
        if ($signed(bus.if_temp) < $signed(min_q)) min_d = bus.if_temp;
        if ($signed(bus.if_temp) > $signed(max_q)) max_d = bus.if_temp;
      end
    end

    if (clear_stats) begin
      err_d  = 1'b0;
      min_d  = '0;
      max_d  = '0;
      hist_d = '0;
      cnt_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // values computed before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      wait_q   <= '0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      now_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      // NOTE: the history is reset too because the average output is derived
      // from it and must read 0 straight out of reset.
      hist_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      wait_q   <= wait_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      now_q    <= now_d;
      min_q    <= min_d;
      max_q    <= max_d;
      hist_q   <= hist_d;
      cnt_q    <= cnt_d;
    end
  end

  // 15-bit signed sum of four 13-bit samples; bits [14:2] are the floored mean.
  assign sum = {{2{hist_q[0][12]}}, hist_q[0]} + {{2{hist_q[1][12]}}, hist_q[1]}
             + {{2{hist_q[2][12]}}, hist_q[2]} + {{2{hist_q[3][12]}}, hist_q[3]};

  assign busy       = (state_q != IDLE);
  assign temp_now   = now_q;
  assign temp_min   = min_q;
  assign temp_max   = max_q;
  assign temp_avg   = sum[14:2];
  assign sample_cnt = cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mcp9808_sampler.sv
// Self-checking bench for mcp9808_sampler: behavioural sensor, sample-list
// reference model, directed corner cases and randomized triggered reads.
module tb_mcp9808_sampler;

  localparam int PERIOD  = 32;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst, enable, trig, clear_stats;
  logic        busy, sample_valid, err;
  logic [12:0] temp_now, temp_min, temp_max, temp_avg;
  logic [15:0] sample_cnt;

  mcp9808_sampler_if bus();

  mcp9808_sampler #(.PERIOD_CYCLES(PERIOD), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .trig(trig), .clear_stats(clear_stats),
    .bus(bus), .busy(busy), .sample_valid(sample_valid), .temp_now(temp_now),
    .temp_min(temp_min), .temp_max(temp_max), .temp_avg(temp_avg),
    .sample_cnt(sample_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle counter and log of cycles on which if_update was seen high.
  int cyc = 0;
  int upd_cyc[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.if_update === 1'b1) upd_cyc.push_back(cyc);

  // Behavioural sensor: drops ready the cycle after an update, holds it low for
  // sensor_len cycles, then returns next_temp. stuck=1 means it never reacts.
  logic [12:0] next_temp  = '0;
  int          sensor_len = 10;
  bit          stuck      = 1'b0;

  initial begin
    bus.if_ready = 1'b1;
    bus.if_temp  = '0;
    forever begin
      @(posedge clk);
      if (bus.if_update === 1'b1 && !stuck) begin
        #1 bus.if_ready = 1'b0;
        repeat (sensor_len) @(posedge clk);
        #1;
        bus.if_temp  = next_temp;
        bus.if_ready = 1'b1;
      end
    end
  end

  // Reference model: the list of samples accepted since reset/clear.
  int samples[$];

  function automatic int to_int(input logic [12:0] c);
    return c[12] ? int'(c) - 8192 : int'(c);
  endfunction

  function automatic logic [12:0] exp_min();
    int m;
    if (samples.size() == 0) return '0;
    m = samples[0];
    foreach (samples[i]) if (samples[i] < m) m = samples[i];
    return 13'(m);
  endfunction

  function automatic logic [12:0] exp_max();
    int m;
    if (samples.size() == 0) return '0;
    m = samples[0];
    foreach (samples[i]) if (samples[i] > m) m = samples[i];
    return 13'(m);
  endfunction

  // Mean of the last four samples; missing older ones are the first sample.
  function automatic logic [12:0] exp_avg();
    int s = 0;
    int q;
    if (samples.size() == 0) return '0;
    for (int i = 0; i < 4; i++) begin
      int idx = samples.size() - 1 - i;
      if (idx < 0) idx = 0;
      s += samples[idx];
    end
    q = s / 4;
    if (s < 0 && (s % 4) != 0) q -= 1;
    return 13'(q);
  endfunction

  function automatic logic [15:0] exp_cnt();
    return (samples.size() > 65535) ? 16'hFFFF : 16'(samples.size());
  endfunction

  task automatic check_stats(input string tag);
    check({tag, "_min"}, 32'(temp_min), 32'(exp_min()));
    check({tag, "_max"}, 32'(temp_max), 32'(exp_max()));
    check({tag, "_avg"}, 32'(temp_avg), 32'(exp_avg()));
    check({tag, "_cnt"}, 32'(sample_cnt), 32'(exp_cnt()));
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear_stats = 1'b1;
    @(negedge clk) clear_stats = 1'b0;
    samples.delete();
  endtask

  // Waits (bounded) for one read returning t, checking busy over the whole
  // transaction and the outputs one cycle after sample_valid.
  task automatic expect_read(input string tag, input logic [12:0] t, input int blen,
                             input bit trig_it, input bit trig_mid);
    bit got = 0, seen = 0, busy_gap = 0;
    int since = 0;
    next_temp  = t;
    sensor_len = blen;
    if (trig_it) begin
      @(negedge clk);
      trig = 1'b1;
    end
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      trig = 1'b0;
      if (bus.if_update === 1'b1) seen = 1;
      if (seen && busy !== 1'b1) busy_gap = 1;
      if (sample_valid === 1'b1) got = 1;
      if (seen) begin
        if (trig_mid && since == 3) trig = 1'b1;
        since++;
      end
    end
    check({tag, "_valid"}, 32'(got), 32'd1);
    check({tag, "_busy"}, 32'(busy_gap), 32'd0);
    if (got) samples.push_back(to_int(t));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(sample_valid), 32'd0);
    check({tag, "_now"}, 32'(temp_now), 32'(t));
    check_stats(tag);
  endtask

  initial begin
    bit found, bad;
    rst = 1'b1; enable = 1'b0; trig = 1'b0; clear_stats = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_upd",   32'(bus.if_update), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_now",   32'(temp_now), 32'd0);
    check_stats("rst");

    // Automatic sampling: 32 idle cycles + req + wait_busy + 10 low + capture.
    upd_cyc.delete();
    enable = 1'b1;
    expect_read("per0", 13'h0190, 10, 0, 0);
    expect_read("per1", 13'h0190, 10, 0, 0);
    expect_read("per2", 13'h0190, 10, 0, 0);
    expect_read("per3", 13'h01A0, 10, 0, 0);
    enable = 1'b0;
    check("per_avg_dir", 32'(temp_avg), 32'h0194);
    check("per_min_dir", 32'(temp_min), 32'h0190);
    check("per_max_dir", 32'(temp_max), 32'h01A0);
    if (upd_cyc.size() == 4) begin
      check("per_gap1", 32'(upd_cyc[1] - upd_cyc[0]), 32'(PERIOD + 13));
      check("per_gap3", 32'(upd_cyc[3] - upd_cyc[2]), 32'(PERIOD + 13));
    end else check("per_upd_count", 32'(upd_cyc.size()), 32'd4);

    // Negative numbers and flooring.
    pulse_clear();
    expect_read("neg0", 13'h1FF0, 6, 1, 0);
    expect_read("neg1", 13'h0010, 6, 1, 0);
    check("neg_min_dir", 32'(temp_min), 32'h1FF0);
    check("neg_max_dir", 32'(temp_max), 32'h0010);
    check("neg_avg_dir", 32'(temp_avg), 32'h1FF8);

    // Timeout with ready stuck high.
    stuck = 1'b1;
    found = 0; bad = 0;
    @(negedge clk) trig = 1'b1;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      trig = 1'b0;
      if (bus.if_update === 1'b1) found = 1;
    end
    check("to_upd_seen", 32'(found), 32'd1);
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) bad = 1;
      if (i == TIMEOUT) check("to_err_before", 32'(err), 32'd0);
    end
    @(negedge clk);
    check("to_err",  32'(err), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check("to_novalid", 32'(bad), 32'd0);
    check_stats("to");
    stuck = 1'b0;
    enable = 1'b1;
    expect_read("to_next", 13'h00C8, 10, 0, 0);
    enable = 1'b0;
    check("to_err_kept", 32'(err), 32'd1);
    pulse_clear();
    @(negedge clk);
    check("clr_err", 32'(err), 32'd0);
    check("clr_cnt", 32'(sample_cnt), 32'd0);
    check_stats("clr");

    // Trigger during WAIT_DONE gives exactly one extra read straight after.
    upd_cyc.delete();
    expect_read("mid0", 13'h0123, 10, 1, 1);
    expect_read("mid1", 13'h0456, 10, 0, 0);
    repeat (60) @(negedge clk);
    check("mid_upd_count", 32'(upd_cyc.size()), 32'd2);
    if (upd_cyc.size() >= 2) check("mid_gap", 32'(upd_cyc[1] - upd_cyc[0]), 32'd14);

    // Randomized triggered reads with occasional clears.
    for (int r = 0; r < 16; r++) begin
      if ($urandom_range(0, 5) == 0) pulse_clear();
      expect_read("rnd", 13'($urandom_range(0, 8191)), int'($urandom_range(1, 12)), 1, 0);
    end

    // Reset in WAIT_DONE: the in-flight completion must be ignored.
    sensor_len = 10;
    found = 0; bad = 0;
    @(negedge clk) trig = 1'b1;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      trig = 1'b0;
      if (bus.if_update === 1'b1) found = 1;
    end
    check("rstm_upd_seen", 32'(found), 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    samples.delete();
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (sample_valid === 1'b1 || bus.if_update === 1'b1) bad = 1;
    end
    check("rstm_ready_back", 32'(bus.if_ready), 32'd1);
    check("rstm_novalid", 32'(bad), 32'd0);
    check("rstm_busy", 32'(busy), 32'd0);
    check("rstm_now",  32'(temp_now), 32'd0);
    check("rstm_err",  32'(err), 32'd0);
    check_stats("rstm");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
